// File: rtl/uart_pkg.sv
// Shared definitions for the UART peripheral: bus command bits, status bit
// positions and the state encoding used by both serial FSMs.
package uart_pkg;

  localparam int CMD_PUSH  = 8;
  localparam int CMD_RXACK = 9;
  localparam int CMD_CLR   = 10;

  localparam int ST_RX_VALID  = 8;
  localparam int ST_RX_OVR    = 9;
  localparam int ST_RX_FERR   = 10;
  localparam int ST_TX_FULL   = 11;
  localparam int ST_TX_EMPTY  = 12;
  localparam int ST_TX_BUSY   = 13;
  localparam int ST_TX_OVF    = 14;
  localparam int ST_COUNT_LSB = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous circular-buffer FIFO; the buffer storage itself is not reset,
// only the pointers and count, so reset discards the contents.
module uart_fifo #(
  parameter int AW = 3,
  parameter int DW = 8
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  // push/pop act as valid strobes; full/empty are the ready terms. A push into
  // a full FIFO is taken only when a pop frees the head slot in the same cycle.
  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH[AW:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_io.sv
// Memory-mapped 8N1 UART: TX byte FIFO feeding a serializer, RX deserializer
// with a one-byte holding register and sticky error flags.
module uart_io
  import uart_pkg::*;
#(
  parameter int CLK_DIV = 434,
  parameter int FIFO_AW = 3
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        WE,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        TXD,
  input  logic        RXD
);

  localparam logic [15:0] DIV_M1  = 16'(CLK_DIV - 1);
  localparam logic [15:0] HALF_M1 = 16'(CLK_DIV / 2 - 1);

  logic             cmd_push;
  logic             fifo_pop, fifo_full, fifo_empty;
  logic [7:0]       fifo_dout;
  logic [FIFO_AW:0] fifo_count;
  logic             unused_wd;

  uart_state_e tx_state_q, tx_state_d, rx_state_q, rx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
  logic        tx_txd_q, tx_txd_d;
  logic [1:0]  rx_sync_q, rx_sync_d;
  logic        rxd_s, rx_done, rx_bad;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d, rx_ovr_q, rx_ovr_d;
  logic        rx_ferr_q, rx_ferr_d, tx_ovf_q, tx_ovf_d;

  assign cmd_push  = WE && WD[CMD_PUSH];
  assign unused_wd = ^WD[31:11];
  assign rxd_s     = rx_sync_q[1];
  assign rx_sync_d = {rx_sync_q[0], RXD};
  assign TXD       = tx_txd_q;

  uart_fifo #(.AW(FIFO_AW), .DW(8)) u_tx_fifo (
    .CLK   (CLK),
    .RESET (RESET),
    .push  (cmd_push),
    .din   (WD[7:0]),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // TX: the line level is registered so TXD never glitches between states.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_txd_d   = tx_txd_q;
    fifo_pop   = 1'b0;
    case (tx_state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          tx_shift_d = fifo_dout;
          tx_cnt_d   = DIV_M1;
          tx_txd_d   = 1'b0;
          tx_state_d = S_START;
        end
      end
      S_START: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d   = DIV_M1;
          tx_bit_d   = '0;
          tx_txd_d   = tx_shift_q[0];
          tx_state_d = S_DATA;
        end else tx_cnt_d = tx_cnt_q - 1'b1;
      end
      S_DATA: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d = DIV_M1;
          if (tx_bit_q == 3'd7) begin
            tx_txd_d   = 1'b1;
            tx_state_d = S_STOP;
          end else begin
            tx_bit_d   = tx_bit_q + 1'b1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_txd_d   = tx_shift_q[1];
          end
        end else tx_cnt_d = tx_cnt_q - 1'b1;
      end
      S_STOP: begin
        if (tx_cnt_q != '0) tx_cnt_d = tx_cnt_q - 1'b1;
        else if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          tx_shift_d = fifo_dout;
          tx_cnt_d   = DIV_M1;
          tx_txd_d   = 1'b0;
          tx_state_d = S_START;
        end else tx_state_d = S_IDLE;
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  // RX: every sample is taken at the bit midpoint, offset by the half-bit START wait.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_done    = 1'b0;
    rx_bad     = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        if (!rxd_s) begin
          rx_cnt_d   = HALF_M1;
          rx_state_d = S_START;
        end
      end
      S_START: begin
        if (rx_cnt_q != '0) rx_cnt_d = rx_cnt_q - 1'b1;
        else if (rxd_s) rx_state_d = S_IDLE;
        else begin
          rx_cnt_d   = DIV_M1;
          rx_bit_d   = '0;
          rx_state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (rx_cnt_q != '0) rx_cnt_d = rx_cnt_q - 1'b1;
        else begin
          rx_cnt_d   = DIV_M1;
          rx_shift_d = {rxd_s, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 1'b1;
          if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (rx_cnt_q != '0) rx_cnt_d = rx_cnt_q - 1'b1;
        else begin
          rx_done    = rxd_s;
          rx_bad     = !rxd_s;
          rx_state_d = S_IDLE;
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  // Bus clears are applied first so a same-cycle hardware set overrides them.
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    rx_ovr_d   = rx_ovr_q;
    rx_ferr_d  = rx_ferr_q;
    tx_ovf_d   = tx_ovf_q;
    if (WE && WD[CMD_RXACK]) rx_valid_d = 1'b0;
    if (WE && WD[CMD_CLR]) begin
      rx_ovr_d  = 1'b0;
      rx_ferr_d = 1'b0;
      tx_ovf_d  = 1'b0;
    end
    if (cmd_push && fifo_full && !fifo_pop) tx_ovf_d = 1'b1;
    if (rx_done) begin
      rx_data_d  = rx_shift_q;
      rx_valid_d = 1'b1;
      if (rx_valid_q) rx_ovr_d = 1'b1;
    end
    if (rx_bad) rx_ferr_d = 1'b1;
  end

  always_comb begin
    RD                      = '0;
    RD[7:0]                 = rx_data_q;
    RD[ST_RX_VALID]         = rx_valid_q;
    RD[ST_RX_OVR]           = rx_ovr_q;
    RD[ST_RX_FERR]          = rx_ferr_q;
    RD[ST_TX_FULL]          = fifo_full;
    RD[ST_TX_EMPTY]         = fifo_empty;
    RD[ST_TX_BUSY]          = (tx_state_q != S_IDLE);
    RD[ST_TX_OVF]           = tx_ovf_q;
    RD[ST_COUNT_LSB +: 4]   = 4'(fifo_count);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_txd_q   <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_sync_q  <= 2'b11;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
      rx_ferr_q  <= 1'b0;
      tx_ovf_q   <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_txd_q   <= tx_txd_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_sync_q  <= rx_sync_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_ovr_q   <= rx_ovr_d;
      rx_ferr_q  <= rx_ferr_d;
      tx_ovf_q   <= tx_ovf_d;
    end
  end

endmodule

// File: tb/tb_uart_io.sv
// Directed/random bench for uart_io at CLK_DIV=4 against a queue-based model
// of the FIFO, the 8N1 frame format and the status register.
module tb_uart_io;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        txd;
  logic        rxd;

  int n_pass  = 0;
  int n_total = 0;

  // model state
  logic [7:0] exp_q[$];
  logic       m_busy;
  logic [7:0] m_data;
  logic       m_valid, m_ovr, m_ferr, m_txovf;

  uart_io #(.CLK_DIV(DIV), .FIFO_AW(3)) dut (
    .CLK   (clk),
    .RESET (rst),
    .WE    (we),
    .WD    (wd),
    .RD    (rd),
    .TXD   (txd),
    .RXD   (rxd)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_busy  = 1'b0;
    m_data  = 8'h00;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_ferr  = 1'b0;
    m_txovf = 1'b0;
  endtask

  task automatic model_push(input logic [7:0] b);
    if (exp_q.size() == 8) m_txovf = 1'b1;
    else exp_q.push_back(b);
  endtask

  task automatic model_rx(input logic [7:0] b, input logic stop_ok, input logic prev_valid);
    if (stop_ok) begin
      if (prev_valid) m_ovr = 1'b1;
      m_data  = b;
      m_valid = 1'b1;
    end else m_ferr = 1'b1;
  endtask

  function automatic logic [31:0] model_rd();
    logic [31:0] r;
    r        = '0;
    r[7:0]   = m_data;
    r[8]     = m_valid;
    r[9]     = m_ovr;
    r[10]    = m_ferr;
    r[11]    = (exp_q.size() == 8);
    r[12]    = (exp_q.size() == 0);
    r[13]    = m_busy;
    r[14]    = m_txovf;
    r[19:16] = 4'(exp_q.size());
    return r;
  endfunction

  task automatic bus_write(input logic [31:0] d);
    wd = d;
    we = 1'b1;
    tick();
    we = 1'b0;
    wd = '0;
  endtask

  // Entered one step after the cycle in which TXD should have fallen; checks
  // the first and last cycle of each of the 10 bit cells, leaving the bench
  // exactly at the start of the following cell.
  task automatic expect_frame(input logic [7:0] b);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      check($sformatf("tx_bit%0d_first", k), {31'b0, txd}, {31'b0, bits[k]});
      repeat (DIV - 1) tick();
      check($sformatf("tx_bit%0d_last", k), {31'b0, txd}, {31'b0, bits[k]});
      tick();
    end
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rxd = bits[k];
      repeat (DIV) tick();
    end
    rxd = 1'b1;
  endtask

  initial begin
    logic [7:0] b;
    logic       pv;
    logic       saw_low;

    rst = 1'b1;
    we  = 1'b0;
    wd  = '0;
    rxd = 1'b1;
    model_reset();
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset_rd", rd, 32'h0000_1000);
    check("reset_rd_model", rd, model_rd());
    check("reset_txd", {31'b0, txd}, 32'd1);

    // single frame, directed pattern
    bus_write(32'h155);
    model_push(8'h55);
    check("push_rd", rd, model_rd());
    check("tx_latency_hi", {31'b0, txd}, 32'd1);
    tick();
    b = exp_q.pop_front();
    m_busy = 1'b1;
    check("tx_started_rd", rd, model_rd());
    expect_frame(b);
    m_busy = 1'b0;
    check("tx_done_rd", rd, model_rd());

    // one frame in flight, then 9 random pushes: FIFO fills and the 9th drops
    b = 8'($urandom_range(0, 255));
    bus_write(32'h100 | 32'(b));
    tick();
    m_busy = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom_range(0, 255));
      bus_write(32'h100 | 32'(b));
      model_push(b);
    end
    check("fifo_full_rd", rd, model_rd());
    repeat (30) tick();
    for (int i = 0; i < 8; i++) begin
      b = exp_q.pop_front();
      expect_frame(b);
    end
    m_busy = 1'b0;
    check("burst_done_rd", rd, model_rd());
    bus_write(32'h400);
    m_txovf = 1'b0;
    check("clr_txovf_rd", rd, model_rd());

    // receive a directed frame, then an unacknowledged random one
    rx_frame(8'hA5, 1'b1);
    repeat (4) tick();
    model_rx(8'hA5, 1'b1, m_valid);
    check("rx_a5_rd", rd, model_rd());
    b = 8'($urandom_range(0, 255));
    rx_frame(b, 1'b1);
    repeat (4) tick();
    model_rx(b, 1'b1, m_valid);
    check("rx_overrun_rd", rd, model_rd());

    // bad stop bit leaves the held byte and rx_valid alone
    b = 8'($urandom_range(0, 255));
    rx_frame(b, 1'b0);
    repeat (8) tick();
    model_rx(b, 1'b0, m_valid);
    check("rx_ferr_rd", rd, model_rd());

    bus_write(32'h200);
    m_valid = 1'b0;
    check("rx_ack_rd", rd, model_rd());

    // one-cycle low pulse is rejected as a glitch
    rxd = 1'b0;
    tick();
    rxd = 1'b1;
    repeat (12) tick();
    check("rx_glitch_rd", rd, model_rd());

    bus_write(32'h400);
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
    check("clr_rx_flags_rd", rd, model_rd());

    // ack+clear issued in the very cycle a new byte completes: the sets win
    b = 8'($urandom_range(0, 255));
    rx_frame(b, 1'b1);
    repeat (4) tick();
    model_rx(b, 1'b1, m_valid);
    check("rx_before_collide_rd", rd, model_rd());
    b = 8'($urandom_range(0, 255));
    rx_frame(b, 1'b1);
    bus_write(32'h600);
    pv = m_valid;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_ferr  = 1'b0;
    m_txovf = 1'b0;
    model_rx(b, 1'b1, pv);
    check("rx_collide_rd", rd, model_rd());

    // reset in the middle of a frame with bytes still queued
    b = 8'($urandom_range(0, 255)) & 8'hFB;
    bus_write(32'h100 | 32'(b));
    for (int i = 0; i < 3; i++) bus_write(32'h100 | 32'($urandom_range(0, 255)));
    repeat (10) tick();
    check("tx_mid_bit2", {31'b0, txd}, {31'b0, b[2]});
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_async_txd", {31'b0, txd}, 32'd1);
    check("rst_async_rd", rd, model_rd());
    #2;
    rst = 1'b0;
    saw_low = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (txd !== 1'b1) saw_low = 1'b1;
    end
    check("post_rst_txd_idle", {31'b0, saw_low}, 32'd0);
    check("post_rst_rd", rd, 32'h0000_1000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
